// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a 2-entry output skid buffer.
// Optional retire/illegal statistics counters are enabled by defining IMMGEN_STATS_EN.
module imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter bit PRESHIFT = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
`ifdef IMMGEN_STATS_EN
   ,
   output logic [31:0]     stat_retired,
   output logic [15:0]     stat_illegal
`endif
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;

   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_t;
   typedef enum logic [1:0] {HD_HOLD = 2'd0, HD_NEW = 2'd1, HD_SKID = 2'd2, HD_CLEAR = 2'd3} head_sel_t;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } entry_t;

   function automatic entry_t decode(input logic [31:0] i);
      entry_t     e;
      logic [31:0] raw;
      logic       halve;
      raw       = 32'd0;
      halve     = 1'b0;
      e.fmt     = FMT_NONE;
      e.illegal = 1'b0;
      case (i[6:0])
         OPC_LUI: begin
            raw   = {i[31:12], 12'd0};
            e.fmt = FMT_U;
         end
         OPC_AUIPC: begin
            raw   = {i[31:12], 12'd0};
            e.fmt = FMT_U;
            halve = 1'b1;
         end
         OPC_JAL: begin
            raw   = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            e.fmt = FMT_J;
            halve = 1'b1;
         end
         OPC_JALR, OPC_LOAD: begin
            raw   = {{20{i[31]}}, i[31:20]};
            e.fmt = FMT_I;
         end
         OPC_OPIMM: begin
            if ((i[14:12] == 3'b001) || (i[14:12] == 3'b101)) begin
               raw   = (XLEN == 64) ? {26'd0, i[25:20]} : {27'd0, i[24:20]};
               e.fmt = FMT_SHAMT;
            end else begin
               raw   = {{20{i[31]}}, i[31:20]};
               e.fmt = FMT_I;
            end
         end
         OPC_STORE: begin
            raw   = {{20{i[31]}}, i[31:25], i[11:7]};
            e.fmt = FMT_S;
         end
         OPC_BRANCH: begin
            raw   = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            e.fmt = FMT_B;
            halve = 1'b1;
         end
         OPC_OP: begin
            e.fmt = FMT_NONE;
         end
         default: begin
            e.illegal = 1'b1;
         end
      endcase
      // Sign-extend the 32-bit value; shamt values have raw[31]=0 so they stay zero-extended.
      e.imm       = {XLEN{raw[31]}};
      e.imm[31:0] = raw;
      if (PRESHIFT && halve) begin
         e.imm = {e.imm[XLEN-1], e.imm[XLEN-1:1]};
      end
      return e;
   endfunction

   state_t    state_r, state_nxt_s;
   head_sel_t head_sel_s;
   logic      skid_load_s;
   entry_t    head_r, skid_r, dec_s;
   logic      in_ready_r, out_valid_r;
   logic      accept_s, retire_s;

   assign accept_s = in_valid & in_ready_r;
   assign retire_s = out_valid_r & out_ready;
   assign dec_s    = decode(inst);

   // State register plus registered handshake flags derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         in_ready_r  <= (state_nxt_s != ST_FULL);
         out_valid_r <= (state_nxt_s != ST_EMPTY);
      end
   end

   // Occupancy transitions.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) state_nxt_s = ST_ONE;
            else          state_nxt_s = ST_EMPTY;
         end
         ST_ONE: begin
            if (accept_s && !retire_s)      state_nxt_s = ST_FULL;
            else if (retire_s && !accept_s) state_nxt_s = ST_EMPTY;
            else                            state_nxt_s = ST_ONE;
         end
         ST_FULL: begin
            if (retire_s) state_nxt_s = ST_ONE;
            else          state_nxt_s = ST_FULL;
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
   end

   // Datapath steering for the head (output) and skid entries.
   always_comb begin
      head_sel_s  = HD_HOLD;
      skid_load_s = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) head_sel_s = HD_NEW;
            else          head_sel_s = HD_HOLD;
         end
         ST_ONE: begin
            if (accept_s && retire_s) begin
               head_sel_s = HD_NEW;
            end else if (retire_s) begin
               head_sel_s = HD_CLEAR;
            end else if (accept_s) begin
               skid_load_s = 1'b1;
            end else begin
               head_sel_s = HD_HOLD;
            end
         end
         ST_FULL: begin
            if (retire_s) head_sel_s = HD_SKID;
            else          head_sel_s = HD_HOLD;
         end
         default: head_sel_s = HD_CLEAR;
      endcase
   end

   // Head and skid entry registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r <= '0;
         skid_r <= '0;
      end else begin
         case (head_sel_s)
            HD_NEW:   head_r <= dec_s;
            HD_SKID:  head_r <= skid_r;
            HD_CLEAR: head_r <= '0;
            default:  head_r <= head_r;
         endcase
         if (skid_load_s) skid_r <= dec_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign imm       = head_r.imm;
   assign fmt       = head_r.fmt;
   assign illegal   = head_r.illegal;

`ifdef IMMGEN_STATS_EN
   logic [31:0] stat_retired_r;
   logic [15:0] stat_illegal_r;

   // Retire counter wraps; illegal counter saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_retired_r <= 32'd0;
         stat_illegal_r <= 16'd0;
      end else if (retire_s) begin
         stat_retired_r <= stat_retired_r + 32'd1;
         if (head_r.illegal && (stat_illegal_r != 16'hFFFF)) begin
            stat_illegal_r <= stat_illegal_r + 16'd1;
         end
      end
   end

   assign stat_retired = stat_retired_r;
   assign stat_illegal = stat_illegal_r;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: three configurations (32/0, 64/0, 32/PRESHIFT)
// share stimulus and are compared against a queue-based reference model.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic [31:0] inst;

   logic        rdy_a, rdy_b, rdy_c, val_a, val_b, val_c, ill_a, ill_b, ill_c;
   logic [31:0] imm_a, imm_c;
   logic [63:0] imm_b;
   logic [2:0]  fmt_a, fmt_b, fmt_c;
`ifdef IMMGEN_STATS_EN
   logic [31:0] sr_a, sr_b, sr_c;
   logic [15:0] si_a, si_b, si_c;
`endif

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .PRESHIFT(1'b0)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .inst(inst),
      .out_valid(val_a), .out_ready(out_ready), .imm(imm_a), .fmt(fmt_a), .illegal(ill_a)
`ifdef IMMGEN_STATS_EN
      , .stat_retired(sr_a), .stat_illegal(si_a)
`endif
   );

   imm_gen_pipe #(.XLEN(64), .PRESHIFT(1'b0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .inst(inst),
      .out_valid(val_b), .out_ready(out_ready), .imm(imm_b), .fmt(fmt_b), .illegal(ill_b)
`ifdef IMMGEN_STATS_EN
      , .stat_retired(sr_b), .stat_illegal(si_b)
`endif
   );

   imm_gen_pipe #(.XLEN(32), .PRESHIFT(1'b1)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .inst(inst),
      .out_valid(val_c), .out_ready(out_ready), .imm(imm_c), .fmt(fmt_c), .illegal(ill_c)
`ifdef IMMGEN_STATS_EN
      , .stat_retired(sr_c), .stat_illegal(si_c)
`endif
   );

   int          tests = 0;
   int          fails = 0;
   logic [31:0] q[$];
   logic [31:0] stat_ret_m;
   logic [15:0] stat_ill_m;
   bit          after_reset;
   logic [6:0]  opc_tbl [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

   // Reference decode: value of the immediate as a signed number, format and legality.
   function automatic longint ref_dec(input logic [31:0] i, input int xlen, input bit pre,
                                      output logic [2:0] f, output bit ill);
      longint      v;
      logic [11:0] s12;
      logic [12:0] b13;
      logic [20:0] j21;
      logic [31:0] u32;
      v = 0; f = 3'd0; ill = 1'b0;
      case (i[6:0])
         7'b0110111: begin u32 = {i[31:12], 12'h000}; v = longint'($signed(u32)); f = 3'd4; end
         7'b0010111: begin
            u32 = {i[31:12], 12'h000}; v = longint'($signed(u32)); f = 3'd4;
            if (pre) v = v >>> 1;
         end
         7'b1101111: begin
            j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = longint'($signed(j21)); f = 3'd5;
            if (pre) v = v >>> 1;
         end
         7'b1100011: begin
            b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = longint'($signed(b13)); f = 3'd3;
            if (pre) v = v >>> 1;
         end
         7'b1100111, 7'b0000011: begin s12 = i[31:20]; v = longint'($signed(s12)); f = 3'd1; end
         7'b0100011: begin s12 = {i[31:25], i[11:7]}; v = longint'($signed(s12)); f = 3'd2; end
         7'b0010011: begin
            if (i[14:12] == 3'b001 || i[14:12] == 3'b101) begin
               v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]); f = 3'd6;
            end else begin
               s12 = i[31:20]; v = longint'($signed(s12)); f = 3'd1;
            end
         end
         7'b0110011: begin v = 0; f = 3'd0; end
         default: ill = 1'b1;
      endcase
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_dut(input string nm, input logic rdy, input logic val, input logic [63:0] im,
                          input logic [2:0] f, input logic il, input int xlen, input bit pre);
      longint     v;
      logic [2:0] ef;
      bit         eil;
      chk({nm, "_in_ready"}, 64'(rdy), 64'(q.size() < 2));
      chk({nm, "_out_valid"}, 64'(val), 64'(q.size() > 0));
      if (q.size() > 0) begin
         v = ref_dec(q[0], xlen, pre, ef, eil);
         chk({nm, "_imm"}, im, (xlen == 32) ? {32'd0, v[31:0]} : v);
         chk({nm, "_fmt"}, 64'(f), 64'(ef));
         chk({nm, "_illegal"}, 64'(il), 64'(eil));
      end else if (after_reset) begin
         chk({nm, "_rst_imm"}, im, 64'd0);
         chk({nm, "_rst_fmt"}, 64'(f), 64'd0);
         chk({nm, "_rst_illegal"}, 64'(il), 64'd0);
      end
   endtask

   task automatic check_all();
      chk_dut("a", rdy_a, val_a, {32'd0, imm_a}, fmt_a, ill_a, 32, 1'b0);
      chk_dut("b", rdy_b, val_b, imm_b, fmt_b, ill_b, 64, 1'b0);
      chk_dut("c", rdy_c, val_c, {32'd0, imm_c}, fmt_c, ill_c, 32, 1'b1);
`ifdef IMMGEN_STATS_EN
      chk("a_stat_retired", 64'(sr_a), 64'(stat_ret_m));
      chk("a_stat_illegal", 64'(si_a), 64'(stat_ill_m));
      chk("b_stat_retired", 64'(sr_b), 64'(stat_ret_m));
      chk("c_stat_illegal", 64'(si_c), 64'(stat_ill_m));
`endif
   endtask

   // One clock: predict transfers from the model, advance it at the edge, check at the falling edge.
   task automatic step();
      bit         acc, ret, eil;
      logic [2:0] ef;
      longint     v;
      acc = !rst && in_valid && (q.size() < 2);
      ret = !rst && out_ready && (q.size() > 0);
      @(posedge clk);
      if (rst) begin
         q.delete();
         stat_ret_m  = 32'd0;
         stat_ill_m  = 16'd0;
         after_reset = 1'b1;
      end else begin
         if (ret) begin
            v = ref_dec(q[0], 32, 1'b0, ef, eil);
            stat_ret_m = stat_ret_m + 32'd1;
            if (eil && stat_ill_m != 16'hFFFF) stat_ill_m = stat_ill_m + 16'd1;
            void'(q.pop_front());
         end
         if (acc) begin
            q.push_back(inst);
            after_reset = 1'b0;
         end
      end
      @(negedge clk);
      check_all();
   endtask

   // Present one instruction until the model says it was accepted (bounded).
   task automatic offer(input logic [31:0] w);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      inst = w;
      for (int k = 0; k < 20 && !ok; k++) begin
         ok = (q.size() < 2);
         step();
      end
      tests++;
      assert (ok) else begin
         fails++;
         $error("FAIL accept_timeout: observed not accepted expected accepted");
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inst = 32'd0;
      stat_ret_m = 32'd0; stat_ill_m = 16'd0; after_reset = 1'b1;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      step();

      // Known-answer instructions
      out_ready = 1'b1;
      offer(32'hFFF00093);
      chk("addi_imm", {32'd0, imm_a}, 64'hFFFFFFFF);
      chk("addi_fmt", 64'(fmt_a), 64'd1);
      chk("addi_illegal", 64'(ill_a), 64'd0);
      offer(32'hFE000EE3);
      chk("beq_imm", {32'd0, imm_a}, 64'hFFFFFFFC);
      chk("beq_fmt", 64'(fmt_a), 64'd3);
      chk("beq_preshift_imm", {32'd0, imm_c}, 64'hFFFFFFFE);
      offer(32'h800000B7);
      chk("lui64_imm", imm_b, 64'hFFFFFFFF80000000);
      chk("lui64_fmt", 64'(fmt_b), 64'd4);
      offer(32'h4030D093);
      chk("srai64_imm", imm_b, 64'd3);
      chk("srai64_fmt", 64'(fmt_b), 64'd6);
      offer(32'h0000007F);
      chk("bad_illegal", 64'(ill_a), 64'd1);
      chk("bad_imm", {32'd0, imm_a}, 64'd0);
      step();
`ifdef IMMGEN_STATS_EN
      chk("stat_illegal_one", 64'(si_a), 64'd1);
`endif

      // Back-pressure: three back-to-back pushes with the consumer stalled
      out_ready = 1'b0;
      in_valid = 1'b1;
      inst = 32'h00100093; step();
      inst = 32'h00200093; step();
      chk("bp_in_ready_full", 64'(rdy_a), 64'd0);
      inst = 32'h00300093; step();
      chk("bp_head_first", {32'd0, imm_a}, 64'd1);
      out_ready = 1'b1; step();
      chk("bp_head_second", {32'd0, imm_a}, 64'd2);
      step();
      chk("bp_head_third", {32'd0, imm_a}, 64'd3);
      in_valid = 1'b0; step();
      chk("bp_drained", 64'(val_a), 64'd0);

      // Reset while FULL discards everything
      out_ready = 1'b0;
      offer(32'h00500093);
      offer(32'h00600093);
      rst = 1'b1; step();
      chk("rst_full_out_valid", 64'(val_a), 64'd0);
      chk("rst_full_in_ready", 64'(rdy_a), 64'd1);
      rst = 1'b0; out_ready = 1'b1;
      step();
      step();
      chk("rst_no_stale", 64'(val_a), 64'd0);

      // Randomised traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         inst = $urandom;
         if ($urandom_range(0, 7) != 0) inst[6:0] = opc_tbl[$urandom_range(0, 8)];
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
